// File: rtl/irq_controller.sv
// Prioritised interrupt controller: synchronises up to eight sources, applies mask and
// edge/level mode, raises one registered request and tracks the source in service until EOI.
module irq_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
  input  logic               clk_ip,
  input  logic               reset_ip,
  input  logic [NUM_SRC-1:0] irq_src_ip,
  input  logic [7:0]         addr_ip,
  input  logic [7:0]         data_ip,
  input  logic               wr_ip,
  output logic [7:0]         data_op,
  output logic               irq_op,
  input  logic               irq_ack_ip,
  output logic [1:0]         dbg_state_op
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [7:0] ADDR_PEND = BASE_ADDR;
  localparam logic [7:0] ADDR_MASK = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_MODE = BASE_ADDR + 8'd2;
  localparam logic [7:0] ADDR_VEC  = BASE_ADDR + 8'd3;
  localparam logic [7:0] ADDR_EOI  = BASE_ADDR + 8'd4;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic               irq_q, irq_d;
  logic               vec_vld_q, vec_vld_d;
  logic [2:0]         vec_id_q, vec_id_d;

  logic [NUM_SRC-1:0] pend_view, qual, edge_det, w1c, ack_clr, onehot;
  logic [2:0]         sel_id;
  logic               any_qual, eoi_wr;

  // Level-mode bits mirror the synchronised input; edge-mode bits come from the latch.
  assign pend_view = (mode_q & pend_q) | (~mode_q & s2_q);
  assign qual      = pend_view & mask_q;
  assign any_qual  = |qual;
  assign edge_det  = s2_q & ~s3_q;
  assign eoi_wr    = wr_ip && (addr_ip == ADDR_EOI);
  assign w1c       = (wr_ip && (addr_ip == ADDR_PEND)) ? data_ip[NUM_SRC-1:0] : '0;

  // Lowest index wins: scan downward so the last hit is the smallest set index.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (qual[i]) sel_id = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_vld_d = vec_vld_q;
    vec_id_d  = vec_id_q;
    onehot    = '0;
    onehot[0] = 1'b1;
    ack_clr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_qual) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (irq_ack_ip && any_qual) begin
          state_d   = ST_SERVICE;
          vec_vld_d = 1'b1;
          vec_id_d  = sel_id;
          ack_clr   = onehot << sel_id;
        end else if (!any_qual) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr) begin
          state_d   = ST_IDLE;
          vec_vld_d = 1'b0;
          vec_id_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clears (W1C, ack) apply first so a same-cycle new edge still sets the bit.
  always_comb begin
    pend_d = ((pend_q & mode_q) & ~w1c & ~ack_clr) | (edge_det & mode_q);
    mask_d = (wr_ip && (addr_ip == ADDR_MASK)) ? data_ip[NUM_SRC-1:0] : mask_q;
    mode_d = (wr_ip && (addr_ip == ADDR_MODE)) ? data_ip[NUM_SRC-1:0] : mode_q;
    irq_d  = (state_d == ST_REQ);
  end

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      state_q   <= ST_IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      irq_q     <= 1'b0;
      vec_vld_q <= 1'b0;
      vec_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= irq_src_ip;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      vec_vld_q <= vec_vld_d;
      vec_id_q  <= vec_id_d;
    end
  end

  always_comb begin
    data_op = 8'h00;
    case (addr_ip)
      ADDR_PEND: data_op[NUM_SRC-1:0] = pend_view;
      ADDR_MASK: data_op[NUM_SRC-1:0] = mask_q;
      ADDR_MODE: data_op[NUM_SRC-1:0] = mode_q;
      ADDR_VEC:  data_op = {vec_vld_q, 4'b0000, vec_id_q};
      default:   data_op = 8'h00;
    endcase
  end

  assign irq_op       = irq_q;
  assign dbg_state_op = state_q;

endmodule

// File: doc/irq_controller.md
# irq_controller

Prioritised interrupt controller sitting between up to eight peripheral interrupt sources and the single `irq_ip` input of the 8-bit CPU core. It synchronises and latches source requests, applies per-source masking and edge/level mode, and presents one registered request line to the core. It tracks the source in service until software issues an end-of-interrupt (EOI). Software configures and inspects the block through five registers on the 8-bit peripheral bus.

## Interface
- `NUM_SRC`, 8, number of interrupt sources (1..8); unused register bits read 0.
- `BASE_ADDR`, 8'hF0, peripheral bus address of register 0; registers occupy BASE_ADDR..BASE_ADDR+4.

- `clk_ip`  in  1  system clock, all state on rising edge.
- `reset_ip`  in  1  asynchronous, active-high reset.
- `irq_src_ip`  in  NUM_SRC  raw source requests, asynchronous to `clk_ip`.
- `addr_ip`  in  8  peripheral bus address.
- `data_ip`  in  8  bus write data.
- `wr_ip`  in  1  write strobe, one cycle per access.
- `data_op`  out  8  bus read data, combinational from `addr_ip`; 8'h00 when address not decoded.
- `irq_op`  out  1  registered interrupt request to core.
- `irq_ack_ip`  in  1  one-cycle pulse from core when it vectors to the handler.

## Operation
- Registers (offset from BASE_ADDR):
  - +0 PEND: read pending bits; write-1-to-clear (edge-mode bits only; level-mode bits ignore writes).
  - +1 MASK: R/W, 1 = enabled. Reset 8'h00.
  - +2 MODE: R/W, 1 = rising-edge, 0 = level-high. Reset 8'h00.
  - +3 VEC: read-only, bit7 = in-service valid, bits[2:0] = in-service source id, others 0.
  - +4 EOI: any write clears the in-service state; reads 8'h00.
- Per source: 2-FF synchroniser s1→s2, plus delay FF s3. Edge = s2 & ~s3.
- Pending: edge mode sets on edge, holds until W1C or ack; level mode follows s2 combinationally into PEND each cycle.
- Qualified = PEND & MASK. Priority fixed: lowest index highest.
- States: IDLE (no in-service), REQ (irq_op=1), SERVICE (in-service valid).
  - IDLE→REQ: any qualified bit; irq_op set next edge.
  - REQ→SERVICE: irq_ack_ip=1; latch highest-priority qualified id into VEC, set bit7, clear that PEND bit if edge mode; irq_op cleared same edge.
  - REQ→IDLE: qualified becomes zero (mask/W1C/level drop) before ack; irq_op cleared next edge.
  - SERVICE→IDLE: EOI write. No nesting: irq_op stays 0 in SERVICE regardless of pending.
- irq_ack_ip in IDLE or SERVICE: ignored. EOI write in IDLE/REQ: ignored.
- Level source still high after EOI: re-requests (IDLE→REQ) normally.

## Timing
- Reset: all registers, synchronisers, PEND, MASK, MODE, VEC = 0; irq_op = 0; state IDLE. Applies immediately mid-operation, including during SERVICE.
- Source latency: source high before edge E0 → s2=1 at E1 → edge-mode PEND set at E2 → irq_op=1 at E3 (if masked-in and IDLE).
- Register writes take effect at the edge where wr_ip=1; reads reflect post-edge state the following cycle.
- Simultaneous events:
  - W1C and new edge on same bit same cycle: set wins.
  - Ack and new edge on a higher-priority source same cycle: ack selects from PEND as registered before that edge; new edge remains pending.
  - Ack and W1C clearing the selected bit same cycle: ack wins (id latched, bit cleared).
  - EOI write and qualified pending same cycle: state IDLE at that edge, irq_op=1 the next edge.
- Pulses shorter than one clock may be missed; edge sources must be high ≥2 clocks.

## Test plan
- Reset: assert reset_ip mid-SERVICE → irq_op=0, VEC=8'h00, MASK=8'h00 immediately, without a clock.
- Single edge: MODE=8'h01, MASK=8'h01, pulse src0 for 3 clocks → PEND=8'h01 at E2, irq_op=1 at E3; ack → VEC=8'h80, PEND=8'h00, irq_op=0; EOI → VEC=8'h00.
- Priority: MODE=8'hFF, MASK=8'hFF, edges on src5 and src2 same cycle → ack gives VEC=8'h82; EOI → irq_op=1 again, ack gives VEC=8'h85.
- Masking: MASK=8'h00, edge on src3 → PEND=8'h08, irq_op stays 0; write MASK=8'h08 → irq_op=1 next edge; write PEND=8'h08 before ack → irq_op=0.
- Level mode: MODE=8'h00, MASK=8'h10, hold src4 high → ack VEC=8'h84; EOI with src4 still high → re-request; drop src4 while in REQ → irq_op falls.
- Stray strobes: ack in IDLE and EOI in IDLE → no state change; unmapped address read → data_op=8'h00.
